// File: rtl/stark_rf_read_bcast_pkg.sv
// ---------------------------------------------------------------------------
// stark_rf_read_bcast_pkg
// Shared types for the register-file read scheduler / broadcaster.
//   pregno_t   : physical register number
//   value_t    : register value
//   value_zero : reset value of the broadcast data lanes
//   NPORT_RF   : number of RF read ports (= broadcast lanes the stations expect)
//   rr_dist    : distance of a slot from the round-robin pointer (scan order rank)
// ---------------------------------------------------------------------------
package stark_rf_read_bcast_pkg;

    localparam int PREG_W   = 7;
    localparam int VALUE_W  = 64;
    localparam int NPORT_RF = 16;

    typedef logic [PREG_W-1:0]  pregno_t;
    typedef logic [VALUE_W-1:0] value_t;

    localparam value_t value_zero = '0;

    // Rank of slot idx in a wrap-around scan that starts at ptr.
    function automatic int rr_dist(input int idx, input int ptr, input int m);
        return (idx >= ptr) ? (idx - ptr) : (idx - ptr + m);
    endfunction

endpackage

// File: rtl/stark_rf_read_bcast_if.sv
// ---------------------------------------------------------------------------
// stark_rf_read_bcast_if
// Bundles the station request bus, the RF read port and the broadcast bus.
//   master : the scheduler (drives RF address/enable and the broadcast bus)
//   slave  : the environment (stations drive requests, RF returns data)
// Signals:
//   req_v/req_prn        station request slots
//   rf_ra/rf_re          RF read address / enable per port (registered)
//   rf_rd/rf_rtag        RF data / tag per port (combinational from rf_ra)
//   prn/prnv/rfo/rfo_tag broadcast lanes
//   grant_cnt            lanes granted in the previous cycle
// ---------------------------------------------------------------------------
interface stark_rf_read_bcast_if
    import stark_rf_read_bcast_pkg::*;
#(
    parameter int NREQ  = 16,
    parameter int NPORT = NPORT_RF,
    parameter int CNT_W = $clog2(NPORT + 1)
);
    logic    [NREQ-1:0]              req_v;
    pregno_t [NREQ-1:0]              req_prn;
    pregno_t [NPORT-1:0]             rf_ra;
    logic    [NPORT-1:0]             rf_re;
    value_t  [NPORT-1:0]             rf_rd;
    logic    [NPORT-1:0]             rf_rtag;
    pregno_t [NPORT-1:0]             prn;
    logic    [NPORT-1:0]             prnv;
    value_t  [NPORT-1:0]             rfo;
    logic    [NPORT-1:0]             rfo_tag;
    logic    [CNT_W-1:0]             grant_cnt;

    modport master (
        input  req_v, req_prn, rf_rd, rf_rtag,
        output rf_ra, rf_re, prn, prnv, rfo, rfo_tag, grant_cnt
    );

    modport slave (
        output req_v, req_prn, rf_rd, rf_rtag,
        input  rf_ra, rf_re, prn, prnv, rfo, rfo_tag, grant_cnt
    );
endinterface

// File: rtl/stark_rf_read_bcast_rr_pick_n.sv
// ---------------------------------------------------------------------------
// stark_rr_pick_n
// Rotating-priority pick of up to N set bits out of M request bits.
// Scanning starts at ptr and wraps; the k-th set bit found goes to lane k.
//   req      in  M            request bits
//   ptr      in  IDX_W        scan start index
//   lane_idx out N x IDX_W    slot index assigned to each lane
//   lane_v   out N            lane carries a pick
//   count    out CNT_W        number of picks (0..N)
//   last_idx out IDX_W        slot index of the last pick (0 when none)
// ---------------------------------------------------------------------------
module stark_rr_pick_n #(
    parameter int M     = 16,
    parameter int N     = 16,
    parameter int IDX_W = $clog2(M),
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [M-1:0]            req,
    input  logic [IDX_W-1:0]        ptr,
    output logic [N-1:0][IDX_W-1:0] lane_idx,
    output logic [N-1:0]            lane_v,
    output logic [CNT_W-1:0]        count,
    output logic [IDX_W-1:0]        last_idx
);
    always_comb begin
        int cnt;
        int s;
        lane_idx = '0;
        lane_v   = '0;
        last_idx = '0;
        cnt      = 0;
        s        = 0;
        for (int i = 0; i < M; i++) begin
            s = int'(ptr) + i;
            if (s >= M) begin
                s = s - M;
            end
            if (req[s] && (cnt < N)) begin
                lane_idx[cnt] = IDX_W'(s);
                lane_v[cnt]   = 1'b1;
                last_idx      = IDX_W'(s);
                cnt           = cnt + 1;
            end
        end
        count = CNT_W'(cnt);
    end
endmodule

// File: rtl/stark_rf_read_bcast.sv
// ---------------------------------------------------------------------------
// stark_rf_read_bcast
// Register-file read-port scheduler and operand broadcaster for the
// reservation stations. Each cycle it filters outstanding preg requests
// (drop preg 0 and pregs already in flight), keeps one request per distinct
// preg, grants up to NPORT of them round-robin, reads the RF, and puts the
// result on the prn/prnv/rfo/rfo_tag bus for exactly one cycle.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   bus  stark_rf_read_bcast_if.master (requests, RF port, broadcast bus)
// Pipeline: grant -> rf_ra/rf_re (edge E0) -> prn/rfo (edge E1).
// ---------------------------------------------------------------------------
module stark_rf_read_bcast
    import stark_rf_read_bcast_pkg::*;
#(
    parameter int NSTN  = 4,
    parameter int NPORT = NPORT_RF
) (
    input  logic                  clk,
    input  logic                  rst,
    stark_rf_read_bcast_if.master bus
);
    localparam int NREQ  = 4 * NSTN;
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(NPORT + 1);

    // Read stage and broadcast stage registers
    pregno_t [NPORT-1:0] rf_ra_reg;
    logic    [NPORT-1:0] rf_re_reg;
    pregno_t [NPORT-1:0] prn_reg;
    logic    [NPORT-1:0] prnv_reg;
    value_t  [NPORT-1:0] rfo_reg;
    logic    [NPORT-1:0] rfo_tag_reg;
    logic    [CNT_W-1:0] grant_cnt_reg;
    logic    [IDX_W-1:0] rr_ptr_reg;
    logic    [IDX_W-1:0] rr_ptr_next;

    logic    [NREQ-1:0]  elig;
    logic    [NREQ-1:0]  cand;

    logic [NPORT-1:0][IDX_W-1:0] lane_idx;
    logic [NPORT-1:0]            lane_v;
    logic [CNT_W-1:0]            pick_cnt;
    logic [IDX_W-1:0]            pick_last;
    pregno_t [NPORT-1:0]         rf_ra_next;

    // A slot is eligible unless its preg is 0 or is already being read or
    // broadcast; the station will see that broadcast, so a second read is waste.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            logic busy;
            always_comb begin
                busy = 1'b0;
                for (int j = 0; j < NPORT; j++) begin
                    if (rf_re_reg[j] && (rf_ra_reg[j] == bus.req_prn[gi])) begin
                        busy = 1'b1;
                    end
                    if (prnv_reg[j] && (prn_reg[j] == bus.req_prn[gi])) begin
                        busy = 1'b1;
                    end
                end
            end
            assign elig[gi] = bus.req_v[gi] && (bus.req_prn[gi] != '0) && !busy;
        end
    endgenerate

    // Dedup: a slot is only a candidate if no eligible slot earlier in the
    // current scan order asks for the same preg. Duplicates ride that lane.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_dedup
            logic dup;
            always_comb begin
                dup = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    if ((j != gi) && elig[j] &&
                        (bus.req_prn[j] == bus.req_prn[gi]) &&
                        (rr_dist(j, int'(rr_ptr_reg), NREQ) <
                         rr_dist(gi, int'(rr_ptr_reg), NREQ))) begin
                        dup = 1'b1;
                    end
                end
            end
            assign cand[gi] = elig[gi] && !dup;
        end
    endgenerate

    stark_rr_pick_n #(
        .M     (NREQ),
        .N     (NPORT),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_pick (
        .req      (cand),
        .ptr      (rr_ptr_reg),
        .lane_idx (lane_idx),
        .lane_v   (lane_v),
        .count    (pick_cnt),
        .last_idx (pick_last)
    );

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_lane
            assign rf_ra_next[gi] = lane_v[gi] ? bus.req_prn[lane_idx[gi]] : '0;
        end
    endgenerate

    // Pointer only advances when every lane was used; otherwise every
    // candidate was served and there is nothing to be fair about.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (pick_cnt == CNT_W'(NPORT)) begin
            rr_ptr_next = (pick_last == IDX_W'(NREQ - 1)) ? '0 : pick_last + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_ra_reg     <= '0;
            rf_re_reg     <= '0;
            prn_reg       <= '0;
            prnv_reg      <= '0;
            rfo_reg       <= {NPORT{value_zero}};
            rfo_tag_reg   <= '0;
            grant_cnt_reg <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            rf_ra_reg     <= rf_ra_next;
            rf_re_reg     <= lane_v;
            grant_cnt_reg <= pick_cnt;
            rr_ptr_reg    <= rr_ptr_next;
            prn_reg       <= rf_ra_reg;
            prnv_reg      <= rf_re_reg;
            rfo_reg       <= bus.rf_rd;
            rfo_tag_reg   <= bus.rf_rtag;
        end
    end

    assign bus.rf_ra     = rf_ra_reg;
    assign bus.rf_re     = rf_re_reg;
    assign bus.prn       = prn_reg;
    assign bus.prnv      = prnv_reg;
    assign bus.rfo       = rfo_reg;
    assign bus.rfo_tag   = rfo_tag_reg;
    assign bus.grant_cnt = grant_cnt_reg;

endmodule

// File: tb/tb_stark_rf_read_bcast.sv
// ---------------------------------------------------------------------------
// tb_stark_rf_read_bcast
// Directed bench for stark_rf_read_bcast with 8 stations (32 slots) and
// 16 lanes. A simple RF model returns a known pattern per preg.
// ---------------------------------------------------------------------------
module tb_stark_rf_read_bcast;
    import stark_rf_read_bcast_pkg::*;

    localparam int NSTN  = 8;
    localparam int NREQ  = 4 * NSTN;
    localparam int NPORT = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    stark_rf_read_bcast_if #(.NREQ(NREQ), .NPORT(NPORT)) bus ();

    stark_rf_read_bcast #(.NSTN(NSTN), .NPORT(NPORT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic value_t rf_val(input pregno_t p);
        return {16'hC0DE, 41'd0, p};
    endfunction

    // RF model: asynchronous read
    always_comb begin
        for (int l = 0; l < NPORT; l++) begin
            bus.rf_rd[l]   = rf_val(bus.rf_ra[l]);
            bus.rf_rtag[l] = ^bus.rf_ra[l];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_v   = '0;
        bus.req_prn = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        clear_req();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rf_re", 64'(bus.rf_re), 64'h0);
        chk("rst_rf_ra0", 64'(bus.rf_ra[0]), 64'h0);
        chk("rst_prnv", 64'(bus.prnv), 64'h0);
        chk("rst_prn0", 64'(bus.prn[0]), 64'h0);
        chk("rst_rfo0", 64'(bus.rfo[0]), 64'h0);
        chk("rst_gcnt", 64'(bus.grant_cnt), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single request: slot 0 asks preg 5
        bus.req_v[0]   = 1'b1;
        bus.req_prn[0] = 7'd5;
        step();
        chk("single_rf_re", 64'(bus.rf_re), 64'h1);
        chk("single_rf_ra0", 64'(bus.rf_ra[0]), 64'd5);
        chk("single_gcnt", 64'(bus.grant_cnt), 64'd1);
        clear_req();
        step();
        chk("single_prnv", 64'(bus.prnv), 64'h1);
        chk("single_prn0", 64'(bus.prn[0]), 64'd5);
        chk("single_rfo0", 64'(bus.rfo[0]), 64'hC0DE_0000_0000_0005);
        chk("single_tag0", 64'(bus.rfo_tag[0]), 64'h0);
        chk("single_re_off", 64'(bus.rf_re), 64'h0);
        step();
        chk("single_prnv_off", 64'(bus.prnv), 64'h0);

        // Duplicate preg 9 on slots 0, 3, 7
        bus.req_v[0] = 1'b1; bus.req_prn[0] = 7'd9;
        bus.req_v[3] = 1'b1; bus.req_prn[3] = 7'd9;
        bus.req_v[7] = 1'b1; bus.req_prn[7] = 7'd9;
        step();
        chk("dup_rf_re", 64'(bus.rf_re), 64'h1);
        chk("dup_rf_ra0", 64'(bus.rf_ra[0]), 64'd9);
        chk("dup_gcnt", 64'(bus.grant_cnt), 64'd1);
        clear_req();
        step();
        chk("dup_prnv", 64'(bus.prnv), 64'h1);
        chk("dup_prn0", 64'(bus.prn[0]), 64'd9);
        chk("dup_tag0", 64'(bus.rfo_tag[0]), 64'h0);
        step();

        // Preg 0 is never granted
        bus.req_v[2]   = 1'b1;
        bus.req_prn[2] = 7'd0;
        step();
        chk("p0_rf_re", 64'(bus.rf_re), 64'h0);
        chk("p0_gcnt", 64'(bus.grant_cnt), 64'h0);
        step();
        chk("p0_prnv", 64'(bus.prnv), 64'h0);
        clear_req();
        step();

        // Held request: regrant every third cycle
        bus.req_v[1]   = 1'b1;
        bus.req_prn[1] = 7'd4;
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("hold_re_c%0d", c), 64'(bus.rf_re), 64'((c % 3) == 1));
            chk($sformatf("hold_v_c%0d", c), 64'(bus.prnv), 64'((c % 3) == 2));
        end
        clear_req();
        step();

        // Oversubscribe: 32 distinct pregs 1..32, held
        for (int k = 0; k < NREQ; k++) begin
            bus.req_v[k]   = 1'b1;
            bus.req_prn[k] = pregno_t'(k + 1);
        end
        step();
        chk("ovs1_rf_re", 64'(bus.rf_re), 64'hFFFF);
        chk("ovs1_gcnt", 64'(bus.grant_cnt), 64'd16);
        chk("ovs1_ra0", 64'(bus.rf_ra[0]), 64'd1);
        chk("ovs1_ra15", 64'(bus.rf_ra[15]), 64'd16);
        step();
        chk("ovs2_rf_re", 64'(bus.rf_re), 64'hFFFF);
        chk("ovs2_ra0", 64'(bus.rf_ra[0]), 64'd17);
        chk("ovs2_ra15", 64'(bus.rf_ra[15]), 64'd32);
        chk("ovs2_prnv", 64'(bus.prnv), 64'hFFFF);
        chk("ovs2_prn0", 64'(bus.prn[0]), 64'd1);
        chk("ovs2_prn15", 64'(bus.prn[15]), 64'd16);
        step();
        chk("ovs3_rf_re", 64'(bus.rf_re), 64'h0);
        chk("ovs3_gcnt", 64'(bus.grant_cnt), 64'd0);
        chk("ovs3_prnv", 64'(bus.prnv), 64'hFFFF);
        chk("ovs3_prn15", 64'(bus.prn[15]), 64'd32);
        chk("ovs3_rfo15", 64'(bus.rfo[15]), 64'hC0DE_0000_0000_0020);
        chk("ovs3_tag15", 64'(bus.rfo_tag[15]), 64'h1);
        clear_req();
        step();
        chk("ovs4_prnv", 64'(bus.prnv), 64'h0);

        // Rotation: after a full grant the scan restarts past the last slot
        for (int k = 0; k < NREQ; k++) begin
            bus.req_v[k]   = 1'b1;
            bus.req_prn[k] = pregno_t'(41 + k);
        end
        step();
        chk("rot1_ra0", 64'(bus.rf_ra[0]), 64'd41);
        for (int k = 0; k < 16; k++) begin
            bus.req_prn[k] = pregno_t'(101 + k);
        end
        step();
        chk("rot2_ra0", 64'(bus.rf_ra[0]), 64'd57);
        chk("rot2_ra15", 64'(bus.rf_ra[15]), 64'd72);
        chk("rot2_gcnt", 64'(bus.grant_cnt), 64'd16);
        clear_req();
        step();
        step();
        step();

        // Asynchronous reset between E0 and E1
        bus.req_v[0]   = 1'b1;
        bus.req_prn[0] = 7'd7;
        step();
        chk("arst_pre_re", 64'(bus.rf_re), 64'h1);
        clear_req();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rf_re", 64'(bus.rf_re), 64'h0);
        chk("arst_prnv", 64'(bus.prnv), 64'h0);
        chk("arst_ra0", 64'(bus.rf_ra[0]), 64'h0);
        chk("arst_gcnt", 64'(bus.grant_cnt), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("arst_post_prnv1", 64'(bus.prnv), 64'h0);
        chk("arst_post_re1", 64'(bus.rf_re), 64'h0);
        step();
        chk("arst_post_prnv2", 64'(bus.prnv), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
